// File: rtl/conv_pkg.sv
// Shared code definitions for the rate-1/2, K=3 convolutional encoder and its decoder.
// No logic; constants, generator taps and FSM encoding only.
// Keeping generators and bit order here stops encoder and decoder from drifting apart.
package conv_pkg;

  localparam int K     = 3;
  localparam int MEM_W = K - 1;
  localparam int IN_W  = 8;
  localparam int OUT_W = 2 * IN_W;
  localparam int CNT_W = 16;

  // MSB of each generator taps the newest info bit.
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic {
    RUN  = 1'b0,
    TAIL = 1'b1
  } enc_state_t;

endpackage

// File: rtl/conv_word_enc.sv
// Encodes one info word through the K-1 bit shift register, oldest bit first.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module conv_word_enc
  import conv_pkg::*;
(
  input  logic [IN_W-1:0]  data_in,
  input  logic [MEM_W-1:0] m_in,
  output logic [OUT_W-1:0] data_enc,
  output logic [MEM_W-1:0] m_out
);

  logic [K-1:0] s;

  always_comb begin
    data_enc = '0;
    m_out    = m_in;
    s        = '0;
    // Bit IN_W-1 is first in time; its code pair lands in the top two bits.
    for (int t = 0; t < IN_W; t++) begin
      s                            = {data_in[IN_W-1-t], m_out};
      data_enc[2*(IN_W-1-t) + 1]   = ^(s & G0);
      data_enc[2*(IN_W-1-t)]       = ^(s & G1);
      m_out                        = s[K-1:1];
    end
  end

endmodule

// File: rtl/conv_encoder_par8.sv
// Word-parallel rate-1/2 convolutional encoder with automatic zero-tail frame termination.
// Latency: 1 cycle from accept to data_enc; tail word follows the in_last word.
// Backpressure: single output register, in_ready only when it is empty or draining.
module conv_encoder_par8
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_enc,
  output logic             out_tail,
  output logic [CNT_W-1:0] word_cnt
);

  enc_state_t       state;
  logic [MEM_W-1:0] mem;
  logic             cnt_restart;

  logic             out_free;
  logic             accept;
  logic             tail_load;
  logic             load;
  logic             tail_consumed;
  logic [IN_W-1:0]  enc_din;
  logic [OUT_W-1:0] enc_dout;
  logic [MEM_W-1:0] enc_mout;

  assign out_free      = !out_valid || out_ready;
  assign in_ready      = !rst && (state == RUN) && out_free;
  assign accept        = in_valid && in_ready;
  assign tail_load     = !rst && (state == TAIL) && out_free;
  assign load          = accept || tail_load;
  assign tail_consumed = out_valid && out_ready && out_tail;

  // The tail is just an all-zero word pushed through the same encoder.
  assign enc_din = (state == TAIL) ? '0 : data_in;

  conv_word_enc u_word_enc (
    .data_in  (enc_din),
    .m_in     (mem),
    .data_enc (enc_dout),
    .m_out    (enc_mout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      mem         <= '0;
      out_valid   <= 1'b0;
      data_enc    <= '0;
      out_tail    <= 1'b0;
      word_cnt    <= '0;
      cnt_restart <= 1'b0;
    end else begin
      if (tail_consumed) begin
        cnt_restart <= 1'b1;
      end

      if (load) begin
        data_enc  <= enc_dout;
        out_valid <= 1'b1;
        out_tail  <= tail_load;

        // Counting restarts on the first load of a frame whose predecessor's tail has left.
        if (cnt_restart || tail_consumed) begin
          word_cnt    <= CNT_W'(1);
          cnt_restart <= 1'b0;
        end else if (word_cnt != '1) begin
          word_cnt <= word_cnt + CNT_W'(1);
        end

        if (tail_load) begin
          mem   <= '0;
          state <= RUN;
        end else begin
          mem   <= enc_mout;
          state <= in_last ? TAIL : RUN;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_tail  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    assert (G0[K-1] && G1[K-1])
      else $error("conv_encoder_par8: both generators must tap the newest bit");
  end

endmodule
